// File: rtl/lock_access_controller.sv
// lock_access_controller
//   Door-lock access sequencer. Collects keypad digits into a code buffer and
//   checks the buffer against MAIN_CODE or the optional temporary code. It
//   counts consecutive failed checks, enforces a timed lockout, and lets remote
//   lock/unlock commands override the keypad. lock_cmd is registered.
//   Any key value other than E (LOCK) and F (CLEAR) is a code digit. This lets
//   hex codes such as A5C3 be typed.
//   Optional feature: define AUTO_RELOCK_EN to relock automatically after
//   RELOCK_CYCLES in UNLOCKED.
module lock_access_controller #(
  parameter int          CODE_DIGITS    = 4,
  parameter logic [15:0] MAIN_CODE      = 16'hA5C3,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          ENTRY_TIMEOUT  = 500,
  parameter int          RELOCK_CYCLES  = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        remote_unlock,
  input  logic        remote_lock,
  input  logic [15:0] temp_code,
  input  logic        temp_code_valid,
  output logic        lock_cmd,
  output logic        lockout,
  output logic        entry_busy,
  output logic [2:0]  fail_count
);

  localparam int CODE_W  = 4 * CODE_DIGITS;
  localparam int CNT_W   = $clog2(CODE_DIGITS + 1);
  localparam int TMR_MAX =
    (LOCKOUT_CYCLES > ENTRY_TIMEOUT)
      ? ((LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES)
      : ((ENTRY_TIMEOUT  > RELOCK_CYCLES) ? ENTRY_TIMEOUT  : RELOCK_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Terminal timer values: the transition fires on the edge where the timer
  // already holds limit-1, so the state lasts exactly "limit" cycles.
  localparam logic [TMR_W-1:0] ENTRY_LAST   = TMR_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
  localparam logic [TMR_W-1:0] RELOCK_LAST  = TMR_W'(RELOCK_CYCLES - 1);
`endif
  localparam logic [CNT_W-1:0] LAST_DIGIT   = CNT_W'(CODE_DIGITS - 1);
  localparam logic [2:0]       FAIL_LIMIT   = 3'(MAX_FAILS);
  localparam logic [3:0]       KEY_LOCK     = 4'hE;
  localparam logic [3:0]       KEY_CLEAR    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t              state, state_nxt;
  logic [CODE_W-1:0]   code_buf, code_buf_nxt;
  logic [CNT_W-1:0]    digit_cnt, digit_cnt_nxt;
  logic [TMR_W-1:0]    tmr, tmr_nxt;
  logic [2:0]          fail_q, fail_nxt;
  logic                lock_q;

  logic                key_ok;
  logic                is_digit;
  logic                code_match;

  // Saturating failure counter increment, clamped at MAX_FAILS.
  function automatic logic [2:0] fail_sat_inc(input logic [2:0] v);
    if (v >= FAIL_LIMIT) return FAIL_LIMIT;
    return v + 3'd1;
  endfunction

  // A key arriving together with any remote request is dropped.
  assign key_ok     = key_valid && !remote_lock && !remote_unlock;
  assign is_digit   = (key_digit != KEY_LOCK) && (key_digit != KEY_CLEAR);
  assign code_match = (code_buf == MAIN_CODE) ||
                      (temp_code_valid && (code_buf == temp_code));

  // State, buffer, timer and failure counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      code_buf  <= '0;
      digit_cnt <= '0;
      tmr       <= '0;
      fail_q    <= '0;
      lock_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      code_buf  <= code_buf_nxt;
      digit_cnt <= digit_cnt_nxt;
      tmr       <= tmr_nxt;
      fail_q    <= fail_nxt;
      lock_q    <= (state_nxt == S_UNLOCKED);
    end
  end

  // Next-state logic: keypad sequencing first, then the remote override.
  always_comb begin
    state_nxt     = state;
    code_buf_nxt  = code_buf;
    digit_cnt_nxt = digit_cnt;
    tmr_nxt       = tmr;
    fail_nxt      = fail_q;

    case (state)
      S_IDLE: begin
        if (key_ok && is_digit) begin
          code_buf_nxt  = CODE_W'(key_digit);
          digit_cnt_nxt = CNT_W'(1);
          tmr_nxt       = '0;
          state_nxt     = (CODE_DIGITS == 1) ? S_CHECK : S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (key_ok && is_digit) begin
          code_buf_nxt = (code_buf << 4) | CODE_W'(key_digit);
          tmr_nxt      = '0;
          if (digit_cnt == LAST_DIGIT) begin
            digit_cnt_nxt = '0;
            state_nxt     = S_CHECK;
          end else begin
            digit_cnt_nxt = digit_cnt + CNT_W'(1);
          end
        end else if (key_ok && (key_digit == KEY_CLEAR)) begin
          code_buf_nxt  = '0;
          digit_cnt_nxt = '0;
          tmr_nxt       = '0;
          state_nxt     = S_IDLE;
        end else if (tmr >= ENTRY_LAST) begin
          code_buf_nxt  = '0;
          digit_cnt_nxt = '0;
          tmr_nxt       = '0;
          state_nxt     = S_IDLE;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end

      S_CHECK: begin
        code_buf_nxt  = '0;
        digit_cnt_nxt = '0;
        tmr_nxt       = '0;
        if (code_match) begin
          fail_nxt  = '0;
          state_nxt = S_UNLOCKED;
        end else begin
          fail_nxt  = fail_sat_inc(fail_q);
          state_nxt = (fail_nxt == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
        end
      end

      S_UNLOCKED: begin
        if (key_ok && (key_digit == KEY_LOCK)) begin
          tmr_nxt   = '0;
          state_nxt = S_IDLE;
        end
`ifdef AUTO_RELOCK_EN
        else if (tmr >= RELOCK_LAST) begin
          tmr_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
`endif
      end

      S_LOCKOUT: begin
        if (tmr >= LOCKOUT_LAST) begin
          tmr_nxt   = '0;
          fail_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end

      default: begin
        code_buf_nxt  = '0;
        digit_cnt_nxt = '0;
        tmr_nxt       = '0;
        state_nxt     = S_IDLE;
      end
    endcase

    // Remote requests outrank the keypad. remote_lock leaves the failure
    // count alone and does not shorten an active lockout. In LOCKOUT the door
    // is already locked and the lockout timer keeps running.
    if (remote_lock) begin
      code_buf_nxt  = '0;
      digit_cnt_nxt = '0;
      if (state != S_LOCKOUT) begin
        state_nxt = S_IDLE;
        tmr_nxt   = '0;
        fail_nxt  = fail_q;
      end
    end else if (remote_unlock) begin
      code_buf_nxt  = '0;
      digit_cnt_nxt = '0;
      tmr_nxt       = '0;
      fail_nxt      = '0;
      state_nxt     = S_UNLOCKED;
    end
  end

  assign lock_cmd   = lock_q;
  assign lockout    = (state == S_LOCKOUT);
  assign entry_busy = (state == S_ENTRY);
  assign fail_count = fail_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// tb_lock_access_controller
//   Directed bench for lock_access_controller with hand-computed expectations.
//   Define AUTO_RELOCK_EN for both files to exercise the auto-relock timer.
module tb_lock_access_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        remote_unlock;
  logic        remote_lock;
  logic [15:0] temp_code;
  logic        temp_code_valid;
  logic        lock_cmd;
  logic        lockout;
  logic        entry_busy;
  logic [2:0]  fail_count;

  int n_checks = 0;
  int n_fail   = 0;

  lock_access_controller dut (
    .clk             (clk),
    .rst             (rst),
    .key_valid       (key_valid),
    .key_digit       (key_digit),
    .remote_unlock   (remote_unlock),
    .remote_lock     (remote_lock),
    .temp_code       (temp_code),
    .temp_code_valid (temp_code_valid),
    .lock_cmd        (lock_cmd),
    .lockout         (lockout),
    .entry_busy      (entry_busy),
    .fail_count      (fail_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
  endtask

  // Watchdog: the run is a fixed number of cycles, so this only trips on a hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    key_valid       = 1'b0;
    key_digit       = 4'h0;
    remote_unlock   = 1'b0;
    remote_lock     = 1'b0;
    temp_code       = 16'h0000;
    temp_code_valid = 1'b0;
    tick();
    tick();
    check("rst_lock_cmd",   lock_cmd,   0);
    check("rst_lockout",    lockout,    0);
    check("rst_entry_busy", entry_busy, 0);
    check("rst_fail_count", fail_count, 0);
    rst = 1'b0;
    tick();

    // E/F in IDLE are ignored.
    press(4'hE);
    press(4'hF);
    check("idle_ef_ignored", entry_busy, 0);

    // Correct main code: CHECK one cycle after the last strobe, unlocked the next.
    press(4'hA);
    check("entry_busy_first", entry_busy, 1);
    press(4'h5);
    press(4'hC);
    press(4'h3);
    check("main_check_cycle_lock", lock_cmd, 0);
    tick();
    check("main_unlock", lock_cmd, 1);
    check("main_fail_zero", fail_count, 0);

    // Digits are ignored while unlocked.
    press(4'h1);
    check("unlocked_digit_ignored_lock", lock_cmd, 1);
    check("unlocked_digit_ignored_busy", entry_busy, 0);

    // Both remote requests: lock wins.
    remote_lock   = 1'b1;
    remote_unlock = 1'b1;
    tick();
    remote_lock   = 1'b0;
    remote_unlock = 1'b0;
    check("remote_both_lock", lock_cmd, 0);

    // Three wrong entries: fail_count 1,2,3 then lockout.
    enter4(16'h1234);
    tick();
    check("wrong1_fail", fail_count, 1);
    check("wrong1_no_lockout", lockout, 0);
    enter4(16'h1234);
    tick();
    check("wrong2_fail", fail_count, 2);
    enter4(16'h1234);
    tick();
    check("wrong3_fail", fail_count, 3);
    check("wrong3_lockout", lockout, 1);

    // Correct code typed during lockout is ignored (5 lockout cycles used).
    enter4(16'hA5C3);
    tick();
    check("lockout_code_ignored", lock_cmd, 0);
    check("lockout_no_entry", entry_busy, 0);
    repeat (994) tick();
    check("lockout_last_cycle", lockout, 1);
    tick();
    check("lockout_expired", lockout, 0);
    check("lockout_fail_cleared", fail_count, 0);

    // Lockout again, then remote_unlock clears it.
    for (int k = 0; k < 3; k++) begin
      enter4(16'h9999);
      tick();
    end
    check("relock_lockout", lockout, 1);
    remote_lock = 1'b1;
    tick();
    remote_lock = 1'b0;
    check("remote_lock_keeps_lockout", lockout, 1);
    check("remote_lock_keeps_fail", fail_count, 3);
    remote_unlock = 1'b1;
    tick();
    remote_unlock = 1'b0;
    check("remote_unlock_lock_cmd", lock_cmd, 1);
    check("remote_unlock_lockout", lockout, 0);
    check("remote_unlock_fail", fail_count, 0);

    // E key relocks on the next cycle.
    press(4'hE);
    check("e_key_relock", lock_cmd, 0);

    // Entry timeout: 499 idle cycles keep ENTRY, the 500th drops to IDLE.
    press(4'hA);
    press(4'h5);
    repeat (499) tick();
    check("timeout_not_yet", entry_busy, 1);
    tick();
    check("timeout_entry_busy", entry_busy, 0);
    press(4'hC);
    press(4'h3);
    tick();
    check("timeout_no_unlock", lock_cmd, 0);
    check("timeout_fail_unchanged", fail_count, 0);
    check("timeout_new_entry", entry_busy, 1);
    press(4'hF);
    check("clear_key_idle", entry_busy, 0);
    check("clear_key_no_fail", fail_count, 0);

    // A key together with a remote request is dropped.
    remote_lock = 1'b1;
    press(4'h7);
    remote_lock = 1'b0;
    check("key_dropped_with_remote", entry_busy, 0);

    // Temporary code accepted when valid.
    temp_code       = 16'h1234;
    temp_code_valid = 1'b1;
    enter4(16'h1234);
    tick();
    check("temp_code_unlock", lock_cmd, 1);
`ifdef AUTO_RELOCK_EN
    repeat (1999) tick();
    check("relock_not_yet", lock_cmd, 1);
    tick();
    check("auto_relock", lock_cmd, 0);
`else
    repeat (2000) tick();
    check("no_auto_relock", lock_cmd, 1);
    remote_lock = 1'b1;
    tick();
    remote_lock = 1'b0;
    check("remote_lock_relock", lock_cmd, 0);
`endif

    // Same entry with temp_code_valid low fails.
    temp_code_valid = 1'b0;
    enter4(16'h1234);
    tick();
    check("temp_invalid_no_unlock", lock_cmd, 0);
    check("temp_invalid_fail", fail_count, 1);

    // Asynchronous reset mid-entry discards the digits.
    press(4'h3);
    check("mid_entry_busy", entry_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", entry_busy, 0);
    check("async_rst_fail", fail_count, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
